// File: rtl/z80_bus_ctrl.sv
// Z80 bus controller: decodes CPU memory/I/O/interrupt-acknowledge cycles, inserts
// wait states and drives a sync-RAM window plus a bank of latched I/O channels.
module z80_bus_ctrl #(
    parameter int          MEM_AW   = 10,
    parameter int          IO_CH    = 4,
    parameter logic [7:0]  IO_BASE  = 8'hB8,
    parameter int          WAIT_CYC = 1,
    parameter logic [7:0]  INT_VEC  = 8'hFF
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [15:0]         address,
    input  logic [7:0]          dbus_out,
    input  logic                rd_n,
    input  logic                wr_n,
    input  logic                mreq_n,
    input  logic                iorq_n,
    input  logic                m1_n,
    output logic [7:0]          dbus_in,
    output logic                wait_n,
    output logic [MEM_AW-1:0]   mem_addr,
    output logic [7:0]          mem_din,
    output logic                mem_we,
    input  logic [7:0]          mem_dout,
    output logic [IO_CH-1:0]    io_sel,
    output logic                io_rd,
    output logic                io_wr,
    output logic [7:0]          io_wdata,
    input  logic [8*IO_CH-1:0]  io_rdata,
    output logic [8*IO_CH-1:0]  port_latch,
    output logic [7:0]          unmapped_cnt
);

    typedef enum logic [2:0] {S_IDLE, S_WAIT, S_ACCESS, S_CAPTURE, S_HOLD} state_t;
    localparam logic [1:0] K_MEM = 2'd0, K_IO = 2'd1, K_ACK = 2'd2;

    state_t             state_q, state_d;
    logic [3:0]         cnt_q, cnt_d;
    logic               evt_q, evt_d, arm_q, arm_d, wr_q, wr_d, hit_q, hit_d;
    logic [1:0]         kind_q, kind_d;
    logic [2:0]         ch_q, ch_d;
    logic [7:0]         dbus_in_q, dbus_in_d, io_wdata_q, io_wdata_d, unm_q, unm_d;
    logic [8*IO_CH-1:0] port_latch_q, port_latch_d;

    logic       act, ack, any_req, start, io_hit, mem_hit, start_hit;
    logic [7:0] io_off;

    assign act     = (!mreq_n || !iorq_n) && (!rd_n || !wr_n) && m1_n;
    assign ack     = !iorq_n && !m1_n;
    assign any_req = act || ack;
    // arm_q stays low after reset until the bus has been seen idle once
    assign start   = (state_q == S_IDLE) && any_req && !evt_q && arm_q;

    assign io_off    = address[7:0] - IO_BASE;
    assign io_hit    = io_off < 8'(IO_CH);
    assign mem_hit   = (32'(address) >> MEM_AW) == 32'd0;
    assign start_hit = ack ? 1'b1 : (!iorq_n ? io_hit : mem_hit);

    assign mem_addr     = address[MEM_AW-1:0];
    assign mem_din      = dbus_out;
    assign dbus_in      = dbus_in_q;
    assign io_wdata     = io_wdata_q;
    assign port_latch   = port_latch_q;
    assign unmapped_cnt = unm_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            cnt_q        <= 4'd0;
            evt_q        <= 1'b0;
            arm_q        <= 1'b0;
            wr_q         <= 1'b0;
            hit_q        <= 1'b0;
            kind_q       <= K_MEM;
            ch_q         <= 3'd0;
            dbus_in_q    <= 8'hFF;
            io_wdata_q   <= 8'h00;
            unm_q        <= 8'h00;
            port_latch_q <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            evt_q        <= evt_d;
            arm_q        <= arm_d;
            wr_q         <= wr_d;
            hit_q        <= hit_d;
            kind_q       <= kind_d;
            ch_q         <= ch_d;
            dbus_in_q    <= dbus_in_d;
            io_wdata_q   <= io_wdata_d;
            unm_q        <= unm_d;
            port_latch_q <= port_latch_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (WAIT_CYC > 0) begin
                        state_d = S_WAIT;
                        cnt_d   = 4'(WAIT_CYC);
                    end else begin
                        state_d = S_ACCESS;
                    end
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) state_d = S_ACCESS;
            end
            S_ACCESS:  state_d = (kind_q == K_ACK || !wr_q) ? S_CAPTURE : S_HOLD;
            S_CAPTURE: state_d = S_HOLD;
            S_HOLD:    if (!any_req) state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    always_comb begin
        evt_d        = any_req;
        arm_d        = arm_q || !any_req;
        kind_d       = kind_q;
        wr_d         = wr_q;
        hit_d        = hit_q;
        ch_d         = ch_q;
        dbus_in_d    = dbus_in_q;
        io_wdata_d   = io_wdata_q;
        unm_d        = unm_q;
        port_latch_d = port_latch_q;
        if (start) begin
            kind_d = ack ? K_ACK : (!iorq_n ? K_IO : K_MEM);
            wr_d   = !ack && !wr_n;
            hit_d  = start_hit;
            ch_d   = io_off[2:0];
            if (!ack && !iorq_n && !wr_n && io_hit) io_wdata_d = dbus_out;
            if (!start_hit && unm_q != 8'hFF) unm_d = unm_q + 8'd1;
        end
        if (state_q == S_ACCESS && kind_q == K_IO && wr_q && hit_q)
            port_latch_d[int'(ch_q)*8 +: 8] = dbus_out;
        if (state_q == S_CAPTURE) begin
            if (kind_q == K_ACK)      dbus_in_d = INT_VEC;
            else if (!hit_q)          dbus_in_d = 8'hFF;
            else if (kind_q == K_MEM) dbus_in_d = mem_dout;
            else                      dbus_in_d = io_rdata[int'(ch_q)*8 +: 8];
        end
    end

    always_comb begin
        wait_n = !(state_q == S_WAIT || state_q == S_ACCESS || state_q == S_CAPTURE);
        mem_we = (state_q == S_ACCESS) && kind_q == K_MEM && wr_q && hit_q;
        io_wr  = (state_q == S_ACCESS) && kind_q == K_IO && wr_q && hit_q;
        io_rd  = (state_q == S_ACCESS) && kind_q == K_IO && !wr_q && hit_q;
        io_sel = (io_wr || io_rd) ? (IO_CH'(1) << ch_q) : '0;
    end

endmodule
